// File: rtl/vga_sprite_mixer_if.sv
// ============================================================================
// Module      : vga_sprite_mixer_if
// Description : Request, position-write, ROM and pixel signals of the sprite mixer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_sprite_mixer_if #(
    parameter int H_DISP_LEN = 10,
    parameter int V_DISP_LEN = 10,
    parameter int ROM_AW     = 10
);
    logic                  req_i;
    logic [H_DISP_LEN-1:0] req_h_addr_i;
    logic [V_DISP_LEN-1:0] req_v_addr_i;
    logic                  disp_i;
    logic                  pos_we_i;
    logic [2:0]            pos_sel_i;
    logic [H_DISP_LEN-1:0] pos_x_i;
    logic [V_DISP_LEN-1:0] pos_y_i;
    logic                  pos_vis_i;
    logic [ROM_AW-1:0]     rom_addr_o;
    logic [11:0]           rom_data_i;
    logic [11:0]           rgb_o;
    logic                  frame_o;

    modport master (
        output req_i, req_h_addr_i, req_v_addr_i, disp_i,
        output pos_we_i, pos_sel_i, pos_x_i, pos_y_i, pos_vis_i,
        output rom_data_i,
        input  rom_addr_o, rgb_o, frame_o
    );

    modport slave (
        input  req_i, req_h_addr_i, req_v_addr_i, disp_i,
        input  pos_we_i, pos_sel_i, pos_x_i, pos_y_i, pos_vis_i,
        input  rom_data_i,
        output rom_addr_o, rgb_o, frame_o
    );
endinterface

`default_nettype wire

// File: rtl/vga_sprite_mixer.sv
// ============================================================================
// Module      : vga_sprite_mixer
// Description : Composites a ROM plane sprite, optional bullets (PLANEWAR_BULLET_EN)
//               and background into a pixel aligned with the driver read-ahead.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sprite_mixer #(
    parameter int          H_DISP_LEN = 10,
    parameter int          V_DISP_LEN = 10,
    parameter int          SPR_W      = 32,
    parameter int          SPR_H      = 32,
    parameter int          ROM_DELAY  = 2,
    parameter int          BUL_W      = 4,
    parameter int          BUL_H      = 8,
    parameter logic [11:0] BG_COLOR   = 12'h026,
    parameter logic [11:0] BUL_COLOR  = 12'hFF0,
    parameter logic [11:0] KEY_COLOR  = 12'hF0F
) (
    input  wire logic          clk,
    input  wire logic          rst,
    vga_sprite_mixer_if.slave  bus
);

    localparam int ROM_AW = $clog2(SPR_W * SPR_H);
    localparam int PIPE_N = ROM_DELAY - 1;
    localparam logic [H_DISP_LEN-1:0] c_SPR_W = H_DISP_LEN'(SPR_W);
    localparam logic [V_DISP_LEN-1:0] c_SPR_H = V_DISP_LEN'(SPR_H);

    logic [H_DISP_LEN-1:0] w_h;
    logic [V_DISP_LEN-1:0] w_v;
    logic                  w_commit;
    logic [H_DISP_LEN-1:0] r_sh_px, r_act_px, w_dx;
    logic [V_DISP_LEN-1:0] r_sh_py, r_act_py, w_dy;
    logic                  w_plane_hit;
    logic [ROM_AW-1:0]     w_rom_addr;
    logic                  r_frame;
    logic [PIPE_N-1:0]     r_plane_pipe;
    logic                  w_plane_late;
    logic                  w_bul_late;
    logic [11:0]           r_pix;

    assign w_h      = bus.req_h_addr_i;
    assign w_v      = bus.req_v_addr_i;
    assign w_commit = bus.req_i && (w_h == '0) && (w_v == '0);

    // Commit reads the shadow before any same-cycle write lands in it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_px  <= '0;
            r_sh_py  <= '0;
            r_act_px <= '0;
            r_act_py <= '0;
            r_frame  <= 1'b0;
        end else begin
            if (bus.pos_we_i && (bus.pos_sel_i == 3'd0)) begin
                r_sh_px <= bus.pos_x_i;
                r_sh_py <= bus.pos_y_i;
            end
            if (w_commit) begin
                r_act_px <= r_sh_px;
                r_act_py <= r_sh_py;
            end
            r_frame <= w_commit;
        end
    end

    // Unsigned wrap turns "left of / above the sprite" into a large miss
    assign w_dx        = w_h - r_act_px;
    assign w_dy        = w_v - r_act_py;
    assign w_plane_hit = bus.req_i && (w_dx < c_SPR_W) && (w_dy < c_SPR_H);
    assign w_rom_addr  = ROM_AW'(w_dy) * ROM_AW'(SPR_W) + ROM_AW'(w_dx);
    assign bus.rom_addr_o = (!rst && w_plane_hit) ? w_rom_addr : '0;

`ifdef PLANEWAR_BULLET_EN
    localparam int N_BUL = 4;
    localparam logic [H_DISP_LEN-1:0] c_BUL_W = H_DISP_LEN'(BUL_W);
    localparam logic [V_DISP_LEN-1:0] c_BUL_H = V_DISP_LEN'(BUL_H);

    logic [H_DISP_LEN-1:0] r_sh_bx [N_BUL];
    logic [H_DISP_LEN-1:0] r_act_bx[N_BUL];
    logic [V_DISP_LEN-1:0] r_sh_by [N_BUL];
    logic [V_DISP_LEN-1:0] r_act_by[N_BUL];
    logic [N_BUL-1:0]      r_sh_bv, r_act_bv;
    logic [N_BUL-1:0]      w_bul_hit;
    logic [PIPE_N-1:0]     r_bul_pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_bv  <= '0;
            r_act_bv <= '0;
            for (int k = 0; k < N_BUL; k++) begin
                r_sh_bx[k]  <= '0;
                r_sh_by[k]  <= '0;
                r_act_bx[k] <= '0;
                r_act_by[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_BUL; k++) begin
                if (bus.pos_we_i && (bus.pos_sel_i == 3'(k + 1))) begin
                    r_sh_bx[k] <= bus.pos_x_i;
                    r_sh_by[k] <= bus.pos_y_i;
                    r_sh_bv[k] <= bus.pos_vis_i;
                end
            end
            if (w_commit) begin
                r_act_bx <= r_sh_bx;
                r_act_by <= r_sh_by;
                r_act_bv <= r_sh_bv;
            end
        end
    end

    for (genvar k = 0; k < N_BUL; k++) begin : g_bul
        logic [H_DISP_LEN-1:0] w_bdx;
        logic [V_DISP_LEN-1:0] w_bdy;
        assign w_bdx        = w_h - r_act_bx[k];
        assign w_bdy        = w_v - r_act_by[k];
        assign w_bul_hit[k] = bus.req_i && r_act_bv[k] && (w_bdx < c_BUL_W) && (w_bdy < c_BUL_H);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bul_pipe <= '0;
        end else begin
            r_bul_pipe[0] <= |w_bul_hit;
            for (int i = 1; i < PIPE_N; i++) begin
                r_bul_pipe[i] <= r_bul_pipe[i-1];
            end
        end
    end

    assign w_bul_late = r_bul_pipe[PIPE_N-1];
`else
    logic w_unused_vis;
    assign w_unused_vis = bus.pos_vis_i;
    assign w_bul_late   = 1'b0;
`endif

    // Hit flags travel alongside the ROM read so they meet rom_data_i
    always_ff @(posedge clk) begin
        if (rst) begin
            r_plane_pipe <= '0;
        end else begin
            r_plane_pipe[0] <= w_plane_hit;
            for (int i = 1; i < PIPE_N; i++) begin
                r_plane_pipe[i] <= r_plane_pipe[i-1];
            end
        end
    end

    assign w_plane_late = r_plane_pipe[PIPE_N-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix <= BG_COLOR;
        end else if (w_plane_late && (bus.rom_data_i != KEY_COLOR)) begin
            r_pix <= bus.rom_data_i;
        end else if (w_bul_late) begin
            r_pix <= BUL_COLOR;
        end else begin
            r_pix <= BG_COLOR;
        end
    end

    assign bus.rgb_o   = (bus.disp_i && !rst) ? r_pix : 12'h000;
    assign bus.frame_o = r_frame;

endmodule

`default_nettype wire
